// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer that borrows the shared ALU.
// Produces the low word of op_a*op_b while stalling the pipeline.
module alu_mul_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] OP_ADD = 4'b0010,
  parameter logic [3:0] OP_SLL = 4'b0101,
  parameter logic [3:0] OP_SRL = 4'b0110,
  parameter logic [3:0] OP_NOP = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       ex_sel,
  input  logic [WIDTH-1:0] ex_data_1,
  input  logic [WIDTH-1:0] ex_data_2,
  input  logic [4:0]       ex_shamt,
  input  logic [WIDTH-1:0] alu_out,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_data_1,
  output logic [WIDTH-1:0] alu_data_2,
  output logic [4:0]       alu_shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             w_stop;

  assign w_stop = (r_q == '0) || (r_cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_q      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= op_a;
            r_q   <= op_b;
            r_p   <= '0;
            r_cnt <= '0;
          end
        end
        S_ADD: r_p <= alu_out;
        S_SHL: r_m <= alu_out;
        S_SHR: begin
          r_q   <= alu_out;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: r_result <= r_p;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    alu_sel    = ex_sel;
    alu_data_1 = ex_data_1;
    alu_data_2 = ex_data_2;
    alu_shamt  = ex_shamt;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CHECK;
      end
      S_CHECK: begin
        alu_sel    = OP_NOP;
        alu_data_1 = '0;
        alu_data_2 = '0;
        alu_shamt  = '0;
        if (w_stop)      w_next = S_DONE;
        else if (r_q[0]) w_next = S_ADD;
        else             w_next = S_SHL;
      end
      S_ADD: begin
        alu_sel    = OP_ADD;
        alu_data_1 = r_p;
        alu_data_2 = r_m;
        alu_shamt  = '0;
        w_next     = S_SHL;
      end
      S_SHL: begin
        alu_sel    = OP_SLL;
        alu_data_1 = '0;
        alu_data_2 = r_m;
        alu_shamt  = 5'd1;
        w_next     = S_SHR;
      end
      S_SHR: begin
        alu_sel    = OP_SRL;
        alu_data_1 = '0;
        alu_data_2 = r_q;
        alu_shamt  = 5'd1;
        w_next     = S_CHECK;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  // Bypass so the product is visible in the done cycle itself.
  assign result = done ? r_p : r_result;

endmodule
